mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the multicycle core's single unified memory port. The core (instruction fetch plus load/store) and a program loader/debug requester each issue one transaction at a time. The block grants one owner, holds the owner's command stable on the memory port until the memory signals ready, and returns read data with a one-cycle done pulse. The core has priority, with a starvation guard for the loader and a watchdog that aborts hung memory accesses.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive loader losses after which the loader wins the next contested arbitration (≥1)
- TIMEOUT, 16, maximum BUSY cycles without mem_ready before abort (≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core request; held high until c_done
- c_we  in  1  core write enable
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_gnt  out  1  one-cycle pulse: core transaction accepted
- c_done  out  1  one-cycle pulse: core transaction complete
- c_rdata  out  DW  core read data; valid while c_done=1
- l_req, l_we, l_addr, l_wdata, l_gnt, l_done, l_rdata: same as the c_* ports, for the loader
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completes the current access
- err  out  1  one-cycle pulse, concurrent with done, on timeout abort
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY, RESP. The owner register (CORE/LOADER) is valid in BUSY and RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester.
- IDLE, both requesting: the core wins unless skip_cnt == STARVE_LIMIT, in which case the loader wins.
- Grant edge:
  - latch we/addr/wdata of the winner into the command register
  - set owner; pulse gnt of the winner
  - go to BUSY; clear wd_cnt
- skip_cnt:
  - increments (saturating at STARVE_LIMIT) on a grant edge where l_req=1 and the core wins
  - clears to 0 on a loader grant
  - otherwise holds
- BUSY:
  - mem_en=1; mem_we/addr/wdata driven from the command register (stable for the whole access; requester input changes are ignored)
  - wd_cnt increments each cycle
- BUSY, mem_ready=1: go to RESP; load the owner's rdata register with mem_rdata (we=0) or 0 (we=1); done pulses for the owner.
- BUSY, mem_ready=0 and wd_cnt == TIMEOUT-1: go to RESP with rdata=0; owner's done=1 and err=1.
- RESP: mem_en=0; all requests ignored; always go to IDLE next edge. This guarantees the requester sees done before its req is resampled.
- The non-owner's outputs stay 0 throughout. The non-owner's req is only evaluated in IDLE.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, skip_cnt=0, wd_cnt=0
  - command and rdata registers = 0
  - all outputs 0 the following cycle (gnt, done, err, busy, mem_en, mem_we, mem_addr, mem_wdata, c_rdata, l_rdata)
  - applies mid-transaction: the access is dropped, no done is issued, and the requester must re-request
- All outputs are registered or decoded from registered state only; no combinational path from req or mem_ready to any output.
- Request sampled at edge E0 in IDLE:
  - gnt high and mem_en high in cycle E0–E1
- mem_ready=1 sampled at edge Ek (k≥1):
  - done high and rdata valid in cycle Ek–Ek+1; mem_en=0 in that cycle
  - back in IDLE after Ek+1; earliest next grant at edge Ek+2
- Minimum request-to-done: 1 cycle of mem_en, with done in the second cycle after E0. Minimum gap between grants: 3 cycles.
- Timeout: with mem_ready never asserted, mem_en is high for exactly TIMEOUT cycles, then done+err in the next cycle.
- mem_ready while not in BUSY is ignored.

## Test plan
- Single core read: c_req=1, c_addr=0x40, memory ready on 2nd BUSY cycle with 0xDEADBEEF -> c_gnt 1 cycle; mem_en exactly 2 cycles with mem_addr=0x40, mem_we=0; c_done 1 cycle with c_rdata=0xDEADBEEF; l_* all 0.
- Loader write: l_req=1, l_we=1, l_addr=0x10, l_wdata=0x1234; l_addr changed to 0x99 during BUSY -> mem_addr stays 0x10, mem_wdata=0x1234 until ready; l_done with l_rdata=0.
- Contention/starvation: c_req and l_req both held continuously, memory always ready in 1 cycle, STARVE_LIMIT=4 -> grant sequence C,C,C,C,L,C,C,C,C,L; grants 3 cycles apart.
- Timeout: core read, mem_ready held 0, TIMEOUT=16 -> mem_en high exactly 16 cycles, then c_done=1, err=1, c_rdata=0; next request is serviced normally.
- Reset mid-op: rst=1 on 2nd BUSY cycle of a core read -> next cycle mem_en=0, busy=0, no c_done; skip_cnt=0, verified by a subsequent contended arbitration granting the core.
- Stray ready: mem_ready pulsed in IDLE and RESP -> no state change, no done, no data capture.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single unified memory port.
// Core has priority, with a starvation guard for the loader and a watchdog.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err,
  output logic          busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SKIP_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;   // 0 = core, 1 = loader
  logic            we_reg, we_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   wdata_reg, wdata_next;
  logic [SW-1:0]   skip_cnt_reg, skip_cnt_next;
  logic [WW-1:0]   wd_cnt_reg, wd_cnt_next;
  logic            c_gnt_reg, c_gnt_next;
  logic            l_gnt_reg, l_gnt_next;
  logic            c_done_reg, c_done_next;
  logic            l_done_reg, l_done_next;
  logic            err_reg, err_next;
  logic [DW-1:0]   c_rdata_reg, c_rdata_next;
  logic [DW-1:0]   l_rdata_reg, l_rdata_next;
  logic            pick_loader;
  logic [DW-1:0]   resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      skip_cnt_reg <= '0;
      wd_cnt_reg   <= '0;
      c_gnt_reg    <= 1'b0;
      l_gnt_reg    <= 1'b0;
      c_done_reg   <= 1'b0;
      l_done_reg   <= 1'b0;
      err_reg      <= 1'b0;
      c_rdata_reg  <= '0;
      l_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      skip_cnt_reg <= skip_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
      c_gnt_reg    <= c_gnt_next;
      l_gnt_reg    <= l_gnt_next;
      c_done_reg   <= c_done_next;
      l_done_reg   <= l_done_next;
      err_reg      <= err_next;
      c_rdata_reg  <= c_rdata_next;
      l_rdata_reg  <= l_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    skip_cnt_next = skip_cnt_reg;
    wd_cnt_next   = wd_cnt_reg;
    c_gnt_next    = 1'b0;
    l_gnt_next    = 1'b0;
    c_done_next   = 1'b0;
    l_done_next   = 1'b0;
    err_next      = 1'b0;
    // rdata registers are only non-zero during the done cycle
    c_rdata_next  = '0;
    l_rdata_next  = '0;
    pick_loader   = 1'b0;
    resp_data     = '0;

    case (state_reg)
      IDLE: begin
        if (c_req || l_req) begin
          pick_loader = l_req && (!c_req || skip_cnt_reg == SKIP_MAX);
          state_next  = BUSY;
          owner_next  = pick_loader;
          wd_cnt_next = '0;
          if (pick_loader) begin
            we_next       = l_we;
            addr_next     = l_addr;
            wdata_next    = l_wdata;
            l_gnt_next    = 1'b1;
            skip_cnt_next = '0;
          end else begin
            we_next    = c_we;
            addr_next  = c_addr;
            wdata_next = c_wdata;
            c_gnt_next = 1'b1;
            if (l_req && skip_cnt_reg != SKIP_MAX)
              skip_cnt_next = skip_cnt_reg + 1'b1;
          end
        end
      end

      BUSY: begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if (mem_ready || wd_cnt_reg == WD_LAST) begin
          state_next = RESP;
          // a timed-out access returns zero and flags err
          resp_data  = (mem_ready && !we_reg) ? mem_rdata : '0;
          err_next   = !mem_ready;
          if (owner_reg) begin
            l_done_next  = 1'b1;
            l_rdata_next = resp_data;
          end else begin
            c_done_next  = 1'b1;
            c_rdata_next = resp_data;
          end
        end
      end

      RESP: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign c_gnt     = c_gnt_reg;
  assign l_gnt     = l_gnt_reg;
  assign c_done    = c_done_reg;
  assign l_done    = l_done_reg;
  assign c_rdata   = c_rdata_reg;
  assign l_rdata   = l_rdata_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == BUSY);
  assign mem_we    = mem_en & we_reg;
  assign mem_addr  = mem_en ? addr_reg  : '0;
  assign mem_wdata = mem_en ? wdata_reg : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written sequences for contention, timeout, reset and stray ready.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_done, l_gnt, l_done;
  logic [31:0] c_rdata, l_rdata;
  logic        mem_en, mem_we, mem_ready, err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .busy(busy)
  );

  // ctl = {c_gnt, c_done, l_gnt, l_done, err, busy, mem_en, mem_we}
  typedef struct {
    logic        rst, c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        rdy;
    logic [31:0] mrd;
    logic [7:0]  ctl;
    logic [31:0] maddr, mwd, crd, lrd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic vec_t mkv(
    input logic r, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
    input logic rdy, input logic [31:0] mrd,
    input logic [7:0] ctl, input logic [31:0] ma, input logic [31:0] mw,
    input logic [31:0] crd, input logic [31:0] lrd);
    vec_t v;
    v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
    v.rdy = rdy; v.mrd = mrd; v.ctl = ctl;
    v.maddr = ma; v.mwd = mw; v.crd = crd; v.lrd = lrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold both requests with an always-ready memory and check n grants.
  task automatic collect(input int n, input logic [9:0] exp_loader);
    int got = 0;
    int cyc = 0;
    int prev = 0;
    @(negedge clk);
    c_req = 1; l_req = 1; c_we = 0; l_we = 0;
    c_addr = 32'h100; l_addr = 32'h200; mem_ready = 1; mem_rdata = 32'h0;
    while (got < n && cyc < n * 3 + 10) begin
      @(posedge clk); #1;
      cyc++;
      if (c_gnt || l_gnt) begin
        chk("gnt_excl", {63'd0, c_gnt & l_gnt}, 64'd0);
        chk("gnt_owner", {63'd0, l_gnt}, {63'd0, exp_loader[got]});
        if (got > 0) chk("gnt_gap", 64'(cyc - prev), 64'd3);
        $display("grant %0d: %s at cycle %0d", got, l_gnt ? "L" : "C", cyc);
        prev = cyc;
        got++;
      end
    end
    chk("gnt_count", 64'(got), 64'(n));
    @(negedge clk);
    c_req = 0; l_req = 0;
    repeat (3) @(negedge clk);
    mem_ready = 0;
  endtask

  initial begin
    int en_cnt;
    int cyc;
    logic seen_done;

    rst = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    mem_ready = 0; mem_rdata = 0;

    vecs[0]  = mkv(1, 0,0,32'h0,32'h0,  0,0,32'h0,32'h0,      0,32'h0,       8'b0000_0000, 32'h0,  32'h0,    32'h0,        32'h0);
    vecs[1]  = mkv(1, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0,      0,32'h0,       8'b0000_0000, 32'h0,  32'h0,    32'h0,        32'h0);
    vecs[2]  = mkv(0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0,      0,32'h0,       8'b1000_0110, 32'h40, 32'h0,    32'h0,        32'h0);
    vecs[3]  = mkv(0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0,      0,32'h0,       8'b0000_0110, 32'h40, 32'h0,    32'h0,        32'h0);
    vecs[4]  = mkv(0, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0,      1,32'hDEADBEEF,8'b0100_0100, 32'h0,  32'h0,    32'hDEADBEEF, 32'h0);
    vecs[5]  = mkv(0, 0,0,32'h0,32'h0,  0,0,32'h0,32'h0,      0,32'h0,       8'b0000_0000, 32'h0,  32'h0,    32'h0,        32'h0);
    vecs[6]  = mkv(0, 0,0,32'h0,32'h0,  1,1,32'h10,32'h1234,  0,32'h0,       8'b0010_0111, 32'h10, 32'h1234, 32'h0,        32'h0);
    vecs[7]  = mkv(0, 0,0,32'h0,32'h0,  1,1,32'h99,32'h1234,  0,32'h0,       8'b0000_0111, 32'h10, 32'h1234, 32'h0,        32'h0);
    vecs[8]  = mkv(0, 0,0,32'h0,32'h0,  1,1,32'h99,32'h5678,  0,32'h0,       8'b0000_0111, 32'h10, 32'h1234, 32'h0,        32'h0);
    vecs[9]  = mkv(0, 0,0,32'h0,32'h0,  1,1,32'h99,32'h5678,  1,32'hFFFFFFFF,8'b0001_0100, 32'h0,  32'h0,    32'h0,        32'h0);
    vecs[10] = mkv(0, 0,0,32'h0,32'h0,  0,0,32'h0,32'h0,      1,32'hAAAA,    8'b0000_0000, 32'h0,  32'h0,    32'h0,        32'h0);
    vecs[11] = mkv(0, 0,0,32'h0,32'h0,  0,0,32'h0,32'h0,      0,32'h0,       8'b0000_0000, 32'h0,  32'h0,    32'h0,        32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; c_req = vecs[i].c_req; c_we = vecs[i].c_we;
      c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      l_req = vecs[i].l_req; l_we = vecs[i].l_we;
      l_addr = vecs[i].l_addr; l_wdata = vecs[i].l_wdata;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].mrd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ctl", i), {56'd0, c_gnt, c_done, l_gnt, l_done, err, busy, mem_en, mem_we}, {56'd0, vecs[i].ctl});
      chk($sformatf("vec%0d_mem_addr", i), {32'd0, mem_addr}, {32'd0, vecs[i].maddr});
      chk($sformatf("vec%0d_mem_wdata", i), {32'd0, mem_wdata}, {32'd0, vecs[i].mwd});
      chk($sformatf("vec%0d_c_rdata", i), {32'd0, c_rdata}, {32'd0, vecs[i].crd});
      chk($sformatf("vec%0d_l_rdata", i), {32'd0, l_rdata}, {32'd0, vecs[i].lrd});
      $display("vec %0d: ctl=%b mem_addr=%h c_rdata=%h l_rdata=%h", i,
               {c_gnt, c_done, l_gnt, l_done, err, busy, mem_en, mem_we}, mem_addr, c_rdata, l_rdata);
    end

    // Contention with starvation guard: C,C,C,C,L,C,C,C,C,L
    collect(10, 10'b10_0001_0000);

    // Watchdog timeout on a core read
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h80; mem_ready = 0;
    en_cnt = 0; cyc = 0; seen_done = 0;
    while (!seen_done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_en) en_cnt++;
      if (c_done) begin
        seen_done = 1;
        chk("to_err", {63'd0, err}, 64'd1);
        chk("to_rdata", {32'd0, c_rdata}, 64'd0);
      end
    end
    chk("to_done_seen", {63'd0, seen_done}, 64'd1);
    chk("to_en_cycles", 64'(en_cnt), 64'd16);
    $display("timeout: mem_en cycles=%0d done=%0d", en_cnt, seen_done);
    @(negedge clk); c_req = 0;
    @(negedge clk);

    // Normal read after timeout
    c_req = 1; c_addr = 32'h44; mem_ready = 1; mem_rdata = 32'h5555;
    cyc = 0; seen_done = 0;
    while (!seen_done && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (c_done) begin
        seen_done = 1;
        chk("post_to_err", {63'd0, err}, 64'd0);
        chk("post_to_rdata", {32'd0, c_rdata}, 64'h5555);
      end
    end
    chk("post_to_done_seen", {63'd0, seen_done}, 64'd1);
    $display("post-timeout read: rdata=%h", c_rdata);
    @(negedge clk); c_req = 0; mem_ready = 0;
    @(negedge clk);

    // Saturate the starvation counter, then reset mid-access
    collect(4, 10'b00_0000_0000);
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h60; mem_ready = 0;
    @(posedge clk); #1;
    chk("rst_gnt", {63'd0, c_gnt}, 64'd1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1; c_req = 0;
    @(posedge clk); #1;
    chk("rst_ctl", {61'd0, mem_en, busy, c_done}, 64'd0);
    $display("reset mid-op: mem_en=%b busy=%b c_done=%b", mem_en, busy, c_done);
    @(negedge clk); rst = 0;
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (c_done) seen_done = 1;
    end
    chk("rst_no_done", {63'd0, seen_done}, 64'd0);
    collect(1, 10'b00_0000_0000);

    // Stray ready in RESP must not recapture data or restart
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 32'h20; mem_ready = 0;
    @(posedge clk); #1;
    chk("stray_gnt", {63'd0, c_gnt}, 64'd1);
    @(negedge clk); mem_ready = 1; mem_rdata = 32'h1111;
    @(posedge clk); #1;
    chk("stray_done", {63'd0, c_done}, 64'd1);
    chk("stray_rdata", {32'd0, c_rdata}, 64'h1111);
    @(negedge clk); c_req = 0; mem_ready = 1; mem_rdata = 32'h2222;
    @(posedge clk); #1;
    chk("stray_resp_ctl", {60'd0, c_done, busy, mem_en, err}, 64'd0);
    chk("stray_resp_rdata", {32'd0, c_rdata}, 64'd0);
    $display("stray ready in RESP: c_done=%b busy=%b c_rdata=%h", c_done, busy, c_rdata);
    @(negedge clk); mem_ready = 0;
    @(posedge clk); #1;
    chk("stray_idle", {62'd0, busy, c_gnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
